cmp_seq_ctrl: RTL and testbench
===============================

// Module: cmp_seq_ctrl
// PURPOSE
//  Sequencer for the 2-bit operand comparator feeding the board RGB LED. Drives operand pairs
//  (A,B) onto the comparator, captures its R/G/B result one cycle later, holds it on the LED for
//  a dwell time, blanks, and advances. Auto mode sweeps all 16 pairs; manual mode shows one switch pair.
// PARAMETERS
//  DWELL_CYCLES  25_000_000  cycles a captured result is shown (>=1)
//  GAP_CYCLES    2_500_000   cycles LED blanked between pairs (>=1)
//  PWM_PERIOD    256         PWM period in cycles (only with CMP_SEQ_PWM_EN)
//  PWM_DUTY      64          PWM on-cycles per period, 0..PWM_PERIOD (only with CMP_SEQ_PWM_EN)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  pulse/level; begins a run when in IDLE or DONE
//  abort       in   1  forces return to IDLE, LED off
//  auto_mode   in   1  1 = sweep 16 pairs, 0 = single manual pair; sampled on accepted start
//  continuous  in   1  auto mode: wrap idx 15->0 and keep running; sampled each wrap
//  sw_a        in   2  manual operand A {a1,a0}; sampled on accepted start
//  sw_b        in   2  manual operand B {b1,b0}; sampled on accepted start
//  cmp_r/g/b   in   1  comparator outputs for current op_a/op_b (combinational path)
//  op_a        out  2  operand A to comparator {a1,a0}
//  op_b        out  2  operand B to comparator {b1,b0}
//  led_r/g/b   out  1  LED drive (registered)
//  pair_idx    out  4  current pair, {op_a,op_b}
//  busy        out  1  high in LOAD/SHOW/GAP
//  done        out  1  high in DONE
// BEHAVIOUR
//  Reset: state IDLE; op_a, op_b, pair_idx, led_*, busy, done, counters all 0.
//  States: IDLE, LOAD, SHOW, GAP, DONE (state enum, 3 bits).
//  IDLE/DONE + start (no abort) -> LOAD; auto: idx=0; manual: idx={sw_a,sw_b}. done clears.
//  LOAD (1 cycle): op_a/op_b=idx driven; LED off. -> SHOW.
//  SHOW entry cycle: led_* <= cmp_* (captured once, held, not re-sampled). Stays DWELL_CYCLES
//   cycles (counter 0..DWELL_CYCLES-1), then -> GAP.
//  GAP: led_* = 0 for GAP_CYCLES, op_a/op_b hold. Exit:
//   manual -> DONE; auto, idx<15 -> LOAD with idx+1;
//   auto, idx==15: continuous ? LOAD idx=0 : DONE.
//  DONE: led_* 0, done=1, op_* hold last pair; until start.
//  Latency start->first LED update: 2 cycles (LOAD, SHOW capture edge).
//  abort: any state -> IDLE next edge, led_* 0, counters cleared; abort beats start same cycle.
//  start while busy ignored. auto_mode/sw_* changes mid-run ignored.
//  Counter width: $clog2(max(DWELL_CYCLES,GAP_CYCLES)+1); shared counter, cleared on state change.
//  rst_n asserted mid-run: immediate async return to reset values.
// CONFIGURATION
//  CMP_SEQ_PWM_EN defined: in SHOW, led_* = captured value AND (pwm_cnt < PWM_DUTY); pwm_cnt
//   free-runs 0..PWM_PERIOD-1, reset 0. Output stays registered.
//  Not defined: led_* = captured value steadily in SHOW; no PWM counter synthesised.
// STRUCTURE
//  Package cmp_seq_pkg: state_t enum, NUM_PAIRS=16, OPW=2 operand width.
//  Sub-module cmp_seq_pwm (counter + compare), instantiated only under CMP_SEQ_PWM_EN.
//  Comparator itself stays external; this block only sequences it.
// TESTING  (DWELL_CYCLES=4, GAP_CYCLES=2; bench models cmp_g=(op_a!=op_b), cmp_r=(op_a<op_b), cmp_b=(op_a>op_b))
//  Reset: rst_n=0 mid-SHOW -> all outputs 0 same cycle; state IDLE after release.
//  Manual: sw_a=2'b01, sw_b=2'b10, start -> op=1/2 cycle 1, led_r=1,g=1,b=0 for 4 cycles, 2 blank, done=1.
//  Auto single pass: pair_idx steps 0..15, each 7 cycles (1+4+2), done after 112 cycles; led_g=0 on idx 0,5,10,15.
//  Continuous: auto+continuous -> idx 15 followed by LOAD idx 0; drop continuous -> DONE after next idx 15.
//  Abort+start same cycle in SHOW -> IDLE, led_* 0, busy 0; start while busy -> no restart, idx unchanged.
//  CMP_SEQ_PWM_EN, PWM_PERIOD=4, PWM_DUTY=1 -> in SHOW with cmp_g=1, led_g high 1 of every 4 cycles.

Source files
------------

// File: rtl/cmp_seq_pkg.sv
// Shared types and constants for the comparator sequencer.
package cmp_seq_pkg;

  localparam int NUM_PAIRS = 16;
  localparam int OPW       = 2;
  localparam int IDXW      = 2 * OPW;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SHOW = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Larger of two integers, used to size the shared dwell/gap counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cmp_seq_pwm.sv
// Free-running PWM counter with duty compare for LED dimming.
// Only compiled when CMP_SEQ_PWM_EN is defined.
`ifdef CMP_SEQ_PWM_EN
module cmp_seq_pwm #(
  parameter int PERIOD = 256,
  parameter int DUTY   = 64
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_on
);

  localparam int            PW     = $clog2(PERIOD + 1);
  localparam logic [PW-1:0] LAST   = PW'(PERIOD - 1);
  localparam logic [PW-1:0] DUTY_L = PW'(DUTY);

  logic [PW-1:0] pwm_cnt_q;
  logic [PW-1:0] pwm_cnt_d;

  // Wrap the counter at the end of each period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    if (pwm_cnt_q == LAST) begin
      pwm_cnt_d = '0;
    end else begin
      pwm_cnt_d = pwm_cnt_q + PW'(1);
    end
  end

  // PWM counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign pwm_on = (pwm_cnt_q < DUTY_L);

endmodule
`endif

// File: rtl/cmp_seq_ctrl.sv
// Sequencer for the 2-bit operand comparator driving the RGB LED.
// Walks operand pairs (auto sweep or one manual pair), captures the comparator
// result at SHOW entry, holds it for a dwell time, blanks, then advances.
// Optional LED dimming is enabled by defining CMP_SEQ_PWM_EN.
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 2_500_000,
  parameter int PWM_PERIOD   = 256,
  parameter int PWM_DUTY     = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       auto_mode,
  input  logic       continuous,
  input  logic [1:0] sw_a,
  input  logic [1:0] sw_b,
  input  logic       cmp_r,
  input  logic       cmp_g,
  input  logic       cmp_b,
  output logic [1:0] op_a,
  output logic [1:0] op_b,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b,
  output logic [3:0] pair_idx,
  output logic       busy,
  output logic       done
);

  localparam int              CNTW       = $clog2(max_int(DWELL_CYCLES, GAP_CYCLES) + 1);
  localparam logic [CNTW-1:0] DWELL_LAST = CNTW'(DWELL_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_LAST   = CNTW'(GAP_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_PAIRS - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            auto_q, auto_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [2:0]      cap_q, cap_d;     // captured {r,g,b}
  logic [2:0]      led_q, led_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pwm_on_s;

`ifdef CMP_SEQ_PWM_EN
  cmp_seq_pwm #(
    .PERIOD (PWM_PERIOD),
    .DUTY   (PWM_DUTY)
  ) u_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_on (pwm_on_s)
  );
`else
  // Without dimming the LED is simply on for the whole dwell window.
  logic pwm_cfg_unused;
  assign pwm_cfg_unused = (PWM_PERIOD == PWM_DUTY);
  assign pwm_on_s       = 1'b1;
`endif

  // Next-state, pair index, shared counter and captured result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    auto_d  = auto_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          auto_d  = auto_mode;
          idx_d   = auto_mode ? {IDXW{1'b0}} : {sw_a, sw_b};
          cnt_d   = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        // Operands have been on the comparator for a full cycle; grab the result.
        state_d = S_SHOW;
        cap_d   = {cmp_r, cmp_g, cmp_b};
        cnt_d   = '0;
      end
      S_SHOW: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (!auto_q) begin
            state_d = S_DONE;
          end else if (idx_q != IDX_LAST) begin
            state_d = S_LOAD;
            idx_d   = idx_q + IDXW'(1);
          end else if (continuous) begin
            state_d = S_LOAD;
            idx_d   = {IDXW{1'b0}};
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides everything, including a simultaneous start.
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      state_d = state_d;
    end
  end

  // Registered output values derived from the upcoming state.
  always_comb begin
    led_d  = 3'b000;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_SHOW) begin
      led_d = cap_d & {3{pwm_on_s}};
    end else begin
      led_d = 3'b000;
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_SHOW) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      auto_q  <= 1'b0;
      cnt_q   <= '0;
      cap_q   <= 3'b000;
      led_q   <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      auto_q  <= auto_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign op_a     = idx_q[IDXW-1:OPW];
  assign op_b     = idx_q[OPW-1:0];
  assign pair_idx = idx_q;
  assign led_r    = led_q[2];
  assign led_g    = led_q[1];
  assign led_b    = led_q[0];
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Self-checking bench for cmp_seq_ctrl with a cycle-level reference model.
module tb_cmp_seq_ctrl;

  localparam int D = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       auto_mode = 1'b0;
  logic       continuous = 1'b0;
  logic [1:0] sw_a = 2'd0;
  logic [1:0] sw_b = 2'd0;
  logic       cmp_r, cmp_g, cmp_b;
  logic [1:0] op_a, op_b;
  logic       led_r, led_g, led_b;
  logic [3:0] pair_idx;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  // Reference model: a run is "active", each pair lasts 1+D+G edges,
  // k counts edges since the pair's LOAD.
  bit m_active, m_done, m_auto;
  int m_idx, m_k;
  int pwm_hi;

  cmp_seq_ctrl #(
    .DWELL_CYCLES (D),
    .GAP_CYCLES   (G),
    .PWM_PERIOD   (4),
    .PWM_DUTY     (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .auto_mode  (auto_mode),
    .continuous (continuous),
    .sw_a       (sw_a),
    .sw_b       (sw_b),
    .cmp_r      (cmp_r),
    .cmp_g      (cmp_g),
    .cmp_b      (cmp_b),
    .op_a       (op_a),
    .op_b       (op_b),
    .led_r      (led_r),
    .led_g      (led_g),
    .led_b      (led_b),
    .pair_idx   (pair_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // External comparator.
  assign cmp_g = (op_a != op_b);
  assign cmp_r = (op_a < op_b);
  assign cmp_b = (op_a > op_b);

  function automatic logic [2:0] ref_rgb(input int idx);
    int a, b;
    a = idx / 4;
    b = idx % 4;
    return {a < b, a != b, a > b};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_auto   = 1'b0;
    m_idx    = 0;
    m_k      = 0;
    pwm_hi   = 0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (abort) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
    end else if (!m_active && start) begin
      m_active = 1'b1;
      m_done   = 1'b0;
      m_auto   = auto_mode;
      m_idx    = auto_mode ? 0 : int'({sw_a, sw_b});
      m_k      = 0;
    end else if (m_active) begin
      m_k++;
      if (m_k == 1 + D + G) begin
        m_k = 0;
        if (!m_auto || (m_idx == 15 && !continuous)) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end else begin
          m_idx = (m_idx + 1) % 16;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_led;
    exp_led = (m_active && m_k >= 1 && m_k <= D) ? ref_rgb(m_idx) : 3'b000;
    chk("op_a", 16'(op_a), 16'(m_idx / 4));
    chk("op_b", 16'(op_b), 16'(m_idx % 4));
    chk("pair_idx", 16'(pair_idx), 16'(m_idx));
    chk("busy", 16'(busy), 16'(m_active));
    chk("done", 16'(done), 16'(m_done));
`ifdef CMP_SEQ_PWM_EN
    chk("led_off", 16'({led_r, led_g, led_b} & ~exp_led), 16'd0);
    if (m_active && m_k == 0) pwm_hi = 0;
    if (m_active && m_k >= 1 && m_k <= D && led_g === 1'b1) pwm_hi++;
    if (m_active && m_k == D + 1) begin
      chk("pwm_g_count", 16'(pwm_hi), ref_rgb(m_idx)[1] ? 16'd1 : 16'd0);
      pwm_hi = 0;
    end
`else
    chk("led", 16'({led_r, led_g, led_b}), 16'(exp_led));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    model_reset();

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Directed manual pair 1 vs 2.
    auto_mode = 1'b0;
    sw_a = 2'b01;
    sw_b = 2'b10;
    pulse_start();
    step();
    chk("manual_led_rgb", 16'({led_r, led_g, led_b}), 16'(3'b110));
    repeat (7) step();
    chk("manual_done", 16'(done), 16'd1);

    // Random manual pairs, with switch changes mid-run.
    for (int i = 0; i < 4; i++) begin
      sw_a = 2'($urandom_range(3, 0));
      sw_b = 2'($urandom_range(3, 0));
      pulse_start();
      sw_a = 2'($urandom_range(3, 0));
      auto_mode = 1'($urandom_range(1, 0));
      repeat (8) step();
      auto_mode = 1'b0;
    end

    // Auto single pass: done exactly 112 cycles after start.
    auto_mode = 1'b1;
    continuous = 1'b0;
    pulse_start();
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i % 17 == 3) start = 1'b1;
      else start = 1'b0;
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    start = 1'b0;
    chk("auto_done_latency", 16'(n), 16'd112);

    // Continuous: wrap past 15, then drop continuous and reach DONE.
    continuous = 1'b1;
    pulse_start();
    repeat (130) step();
    chk("cont_still_busy", 16'(busy), 16'd1);
    continuous = 1'b0;
    n = 0;
    for (int i = 1; i <= 250; i++) begin
      step();
      if (done === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("cont_stop_done", 16'(done), 16'd1);

    // Abort and start together while showing.
    auto_mode = 1'b0;
    sw_a = 2'b11;
    sw_b = 2'b00;
    pulse_start();
    step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_led", 16'({led_r, led_g, led_b}), 16'd0);

    // Start held while busy must not restart the sweep.
    auto_mode = 1'b1;
    pulse_start();
    start = 1'b1;
    repeat (10) step();
    start = 1'b0;
    chk("no_restart_idx", 16'(pair_idx), 16'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Asynchronous reset in the middle of SHOW.
    auto_mode = 1'b0;
    sw_a = 2'b10;
    sw_b = 2'b01;
    pulse_start();
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_led", 16'({led_r, led_g, led_b}), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_idx", 16'(pair_idx), 16'd0);
    chk("rst_ops", 16'({op_a, op_b}), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      start      = ($urandom_range(7, 0) == 0);
      abort      = ($urandom_range(59, 0) == 0);
      auto_mode  = 1'($urandom_range(1, 0));
      continuous = ($urandom_range(3, 0) == 0);
      sw_a       = 2'($urandom_range(3, 0));
      sw_b       = 2'($urandom_range(3, 0));
      step();
    end
    start = 1'b0;
    abort = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
